// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
//   Shared definitions for the multi-cycle CPU control sequencer:
//   - state_t  : sequencer state encoding (FETCH..TRAP)
//   - OP_*     : opcode field values the sequencer dispatches on
//   - ALU_*, SRCB_*, PCSRC_* : datapath mux / ALU operation encodings
//   - ctrl_t   : the control word produced by the state decoder
//   Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN adds the trap bit to
//   the control word.
// -----------------------------------------------------------------------------
package multicycle_pkg;

  localparam int ST_BITS = 4;
  localparam int OP_BITS = 6;

  typedef enum logic [ST_BITS-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_TRAP      = 4'd12
  } state_t;

  localparam logic [OP_BITS-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_BITS-1:0] OP_LW    = 6'h23;
  localparam logic [OP_BITS-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_BITS-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_BITS-1:0] OP_J     = 6'h02;
  localparam logic [OP_BITS-1:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       trap;
`endif
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_decode
//   Purely combinational state -> control-word decoder (Moore outputs).
//   In FETCH it requests pc_write/ir_write unconditionally; the top qualifies
//   those two with mem_ready.
//   Ports:
//     i_state : current sequencer state
//     o_ctrl  : datapath control word
//   Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN (decodes TRAP).
// -----------------------------------------------------------------------------
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.i_or_d    = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
      end
      ST_DECODE: begin
        // Branch target precompute: PC + (imm << 2)
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
      end
      ST_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      ST_ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b0;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        o_ctrl.trap = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Main control sequencer for the multi-cycle CPU. Walks each instruction
//   through fetch/decode/execute/memory/writeback and waits on mem_ready for
//   the shared instruction/data memory.
//   Ports:
//     clk, rst_n            : clock (rising edge), async active-low reset
//     opcode                : IR[31:26], sampled in DECODE and MEM_ADDR only
//     mem_ready             : memory access completes this cycle
//     pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//     pc_source             : datapath controls (all 0 while rst_n=0)
//     state                 : current state, for debug
//     trap                  : illegal-opcode indication
//   Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN. When defined, an
//   unrecognised opcode parks the sequencer in TRAP until reset; otherwise it
//   is a NOP and trap is tied to 0.
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm
  import multicycle_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic [ST_W-1:0] state,
  output logic            trap
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_in_fetch;
  logic   w_mem_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:     w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = ST_R_EXEC;
          OP_LW, OP_SW: w_next = ST_MEM_ADDR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          OP_ADDI:      w_next = ST_ADDI_EXEC;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      w_next = ST_TRAP;
`else
          default:      w_next = ST_FETCH;
`endif
        endcase
      end
      ST_MEM_ADDR:  w_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  w_next = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    w_next = ST_FETCH;
      ST_MEM_WRITE: w_next = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    w_next = ST_R_WB;
      ST_R_WB:      w_next = ST_FETCH;
      ST_BRANCH:    w_next = ST_FETCH;
      ST_JUMP:      w_next = ST_FETCH;
      ST_ADDI_EXEC: w_next = ST_ADDI_WB;
      ST_ADDI_WB:   w_next = ST_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      ST_TRAP:      w_next = ST_TRAP;
`endif
      default:      w_next = ST_FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Only the FETCH-cycle IR/PC loads wait on memory; the JUMP pc_write is
  // unconditional.
  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_mem_ok   = ~w_in_fetch | mem_ready;

  // Outputs are gated by rst_n so they drop the instant reset is asserted,
  // without waiting for the state register to settle.
  assign pc_write      = rst_n & w_ctrl.pc_write & w_mem_ok;
  assign ir_write      = rst_n & w_ctrl.ir_write & w_mem_ok;
  assign pc_write_cond = rst_n & w_ctrl.pc_write_cond;
  assign i_or_d        = rst_n & w_ctrl.i_or_d;
  assign mem_read      = rst_n & w_ctrl.mem_read;
  assign mem_write     = rst_n & w_ctrl.mem_write;
  assign mem_to_reg    = rst_n & w_ctrl.mem_to_reg;
  assign reg_dst       = rst_n & w_ctrl.reg_dst;
  assign reg_write     = rst_n & w_ctrl.reg_write;
  assign alu_src_a     = rst_n & w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b & {2{rst_n}};
  assign alu_op        = w_ctrl.alu_op    & {2{rst_n}};
  assign pc_source     = w_ctrl.pc_source & {2{rst_n}};
  assign state         = ST_W'(r_state);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign trap = rst_n & w_ctrl.trap;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Table-driven directed sequences, hand-written reset/trap corner cases and
//   a randomized run against an instruction-path reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       trap;

  int n_vec = 0;
  int n_err = 0;

  multicycle_ctrl_fsm #(.OP_W(6), .ST_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  // Control word order:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
  //  pc_source, trap}
  function automatic logic [16:0] got_ctrl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, trap};
  endfunction

  // Expected controls per state, straight from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input bit rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, tr;
    logic [1:0] sb, op, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, tr} = '0;
    sb = 2'd0; op = 2'd0; ps = 2'd0;
    case (st)
      0:  begin mr = 1; sb = 2'd1; irw = rdy; pw = rdy; end
      1:  begin sb = 2'd3; end
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin sa = 1; op = 2'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 2'd1; pwc = 1; ps = 2'd1; end
      9:  begin pw = 1; ps = 2'd2; end
      10: begin sa = 1; sb = 2'd2; end
      11: begin rw = 1; end
      12: begin tr = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, tr};
  endfunction

  task automatic check(input string tag, input int exp_st, input logic [16:0] exp_c);
    n_vec++;
    if (int'(state) != exp_st) begin
      n_err++;
      $display("FAIL %s state: got %0d want %0d", tag, state, exp_st);
    end
    n_vec++;
    if (got_ctrl() !== exp_c) begin
      n_err++;
      $display("FAIL %s ctrl (state %0d): got %b want %b", tag, exp_st, got_ctrl(), exp_c);
    end
  endtask

  // Called positioned just after a falling edge; leaves at the next one.
  task automatic run_cycle(input logic [5:0] op, input bit rdy, input int exp_st, input string tag);
    opcode = op; mem_ready = rdy;
    #1;
    check(tag, exp_st, exp_ctrl(exp_st, rdy));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b1;
    #1;
    check({tag, "_assert"}, 0, 17'd0);
    @(negedge clk);
    #1;
    check({tag, "_held"}, 0, 17'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] op;
    bit         rdy;
    int         st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] op, input bit rdy, input int st);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st;
    tbl.push_back(v);
  endtask

  // Reference model: queue of upcoming states for the current instruction.
  int q[$];

  function automatic bit is_mem_state(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  task automatic push_path(input logic [5:0] op);
    case (op)
      6'h00: begin q.push_back(6); q.push_back(7); end
      6'h23: begin q.push_back(2); q.push_back(3); q.push_back(4); end
      6'h2B: begin q.push_back(2); q.push_back(5); end
      6'h04: q.push_back(8);
      6'h02: q.push_back(9);
      6'h08: begin q.push_back(10); q.push_back(11); end
      default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        q.push_back(12);
`endif
      end
    endcase
  endtask

  task automatic model_step(input logic [5:0] op, input bit rdy);
    int s;
    s = q[0];
    if (s == 12) return;
    if (is_mem_state(s) && !rdy) return;
    if (s == 1) push_path(op);
    void'(q.pop_front());
    if (q.size() == 0) begin q.push_back(0); q.push_back(1); end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [7];
    int k;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
    ops[4] = 6'h02; ops[5] = 6'h08; ops[6] = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'h11;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    k = $urandom_range(0, 5);
`else
    k = $urandom_range(0, 6);
`endif
    return ops[k];
  endfunction

  initial begin
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;

    // ---------------- directed table ----------------
    // R-type (opcode junk in 6/7 must be ignored)
    add(6'h00, 1, 0); add(6'h00, 1, 1); add(6'h2B, 1, 6); add(6'h23, 1, 7);
    // lw with two wait states in MEM_READ
    add(6'h23, 1, 0); add(6'h23, 1, 1); add(6'h23, 1, 2);
    add(6'h04, 0, 3); add(6'h02, 0, 3); add(6'h23, 1, 3); add(6'h3F, 1, 4);
    // sw
    add(6'h2B, 1, 0); add(6'h2B, 1, 1); add(6'h2B, 1, 2); add(6'h23, 1, 5);
    // beq then j
    add(6'h04, 1, 0); add(6'h04, 1, 1); add(6'h00, 1, 8);
    add(6'h02, 1, 0); add(6'h02, 1, 1); add(6'h23, 1, 9);
    // addi
    add(6'h08, 1, 0); add(6'h08, 1, 1); add(6'h08, 1, 10); add(6'h00, 1, 11);
    // FETCH wait state, then R-type
    add(6'h00, 0, 0); add(6'h00, 0, 0); add(6'h00, 1, 0); add(6'h00, 1, 1);
    add(6'h00, 1, 6); add(6'h00, 1, 7);
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    // illegal opcode behaves as NOP
    add(6'h3F, 1, 0); add(6'h3F, 1, 1); add(6'h00, 1, 0); add(6'h00, 1, 1);
`endif

    @(negedge clk);
    do_reset("reset");
    for (int i = 0; i < tbl.size(); i++)
      run_cycle(tbl[i].op, tbl[i].rdy, tbl[i].st, $sformatf("tbl%0d", i));

    // ---------------- reset during a memory write ----------------
    do_reset("rst2");
    run_cycle(6'h2B, 1, 0, "midrst_f");
    run_cycle(6'h2B, 1, 1, "midrst_d");
    run_cycle(6'h2B, 1, 2, "midrst_a");
    run_cycle(6'h2B, 0, 5, "midrst_w");
    rst_n = 1'b0;
    #1;
    check("midrst_abort", 0, 17'd0);
    @(negedge clk);
    #1;
    check("midrst_hold", 0, 17'd0);
    rst_n = 1'b1;
    run_cycle(6'h00, 1, 0, "midrst_rel");

    // ---------------- randomized run vs. model ----------------
    do_reset("rst3");
    q.delete(); q.push_back(0); q.push_back(1);
    begin
      logic [5:0] cur_op, drv;
      bit rdy;
      int s;
      cur_op = 6'h00;
      for (int c = 0; c < 3000; c++) begin
        s = q[0];
        if (s == 0) cur_op = pick_op();
        drv = (s == 1 || s == 2) ? cur_op : 6'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
        run_cycle(drv, rdy, s, $sformatf("rnd%0d", c));
        model_step(drv, rdy);
      end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    // ---------------- trap on illegal opcode ----------------
    do_reset("rst4");
    run_cycle(6'h3F, 1, 0, "trap_f");
    run_cycle(6'h3F, 1, 1, "trap_d");
    for (int i = 0; i < 6; i++)
      run_cycle(6'($urandom), 1'($urandom), 12, $sformatf("trap_hold%0d", i));
    do_reset("trap_rst");
    run_cycle(6'h00, 1, 0, "trap_rel");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control sequencer for the multi-cycle variant of the CPU.
- Walks each instruction through fetch/decode/execute/memory/writeback.
- Drives every 2:1 and 4:1 datapath mux select, plus the PC, IR, memory and register-file enables.
- Waits on a memory ready handshake, so one shared instruction/data memory with wait states is supported.

Parameters:
- OP_W, 6, opcode field width (instr[31:26])
- ST_W, 4, state register width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (branch)
- i_or_d  out  1  memory address mux select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-data mux select: 0=ALUOut, 1=MDR
- reg_dst  out  1  write-register mux select: 0=rt, 1=rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A mux select: 0=PC, 1=A
- alu_src_b  out  2  ALU B select: 0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- alu_op  out  2  ALU operation: 0=add, 1=sub, 2=funct-decode
- pc_source  out  2  PC mux select: 0=ALU, 1=ALUOut, 2=jump target
- state  out  ST_W  current state, for debug and bench
- trap  out  1  illegal-opcode indication (optional feature only)

Behaviour:
- Reset: asynchronous on rst_n=0. state <= FETCH (0).
- While rst_n=0, every output except state is forced to 0.
- Controls are Moore decodes of state. Exception: pc_write, ir_write and the memory-to-next-state transitions are qualified by mem_ready.
- FETCH (0):
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - If mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
  - If mem_ready=0: hold in FETCH; ir_write=pc_write=0.
- DECODE (1):
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
  - Dispatch on opcode:
    - 0x00 -> R_EXEC
    - 0x23 / 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDI_EXEC
    - other -> FETCH (illegal opcode treated as NOP)
- MEM_ADDR (2): alu_src_a=1, alu_src_b=2, alu_op=0. Next: 0x23 -> MEM_READ, else MEM_WRITE.
- MEM_READ (3): mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB (4): reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WRITE (5): mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
- R_EXEC (6): alu_src_a=1, alu_src_b=0, alu_op=2. Next R_WB.
- R_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next FETCH.
- JUMP (9): pc_write=1, pc_source=2. Next FETCH.
- ADDI_EXEC (10): alu_src_a=1, alu_src_b=2, alu_op=0. Next ADDI_WB.
- ADDI_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- Latency with mem_ready tied high: R/sw/addi 4 cycles, lw 5, beq/j 3. Each memory wait cycle adds 1.
- Any unused state encoding returns to FETCH on the next edge with all outputs 0.
- Reset mid-instruction: the sequence is abandoned immediately; no write strobe is asserted after rst_n falls.
- opcode is only sampled in DECODE and MEM_ADDR; changes in other states are ignored.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE moves to TRAP (12).
  - In TRAP: trap=1 and all other controls are 0. The FSM holds in TRAP until reset.
- Undefined:
  - TRAP state and trap logic are not built. The trap port is tied to 0.
  - An unrecognised opcode returns to FETCH (NOP).

Decomposition:
- Shared package multicycle_pkg holds:
  - the state enum (FETCH..TRAP),
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI,
  - alu_op, alu_src_b and pc_source encodings.
- Sub-module multicycle_ctrl_decode: a purely combinational state -> control-word decoder, instantiated once.
- The top block holds the state register, next-state logic and mem_ready qualification.

Test Plan:
- Reset: rst_n=0 during FETCH with mem_ready=1 -> all controls 0 and state=0. Release -> the next cycle shows mem_read=1 and alu_src_b=1.
- R-type: opcode=0x00, mem_ready=1 -> state sequence 0,1,6,7,0. reg_write=1 with reg_dst=1 only in state 7.
- lw with wait states: opcode=0x23, mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. mem_to_reg=1 in state 4.
- sw: opcode=0x2B -> states 0,1,2,5,0. mem_write=1 for exactly 1 cycle. reg_write is never 1.
- beq then j: opcode=0x04 -> pc_write_cond=1, pc_source=1 in state 8. opcode=0x02 -> pc_write=1, pc_source=2 in state 9.
- Illegal opcode 0x3F:
  - Without MULTICYCLE_ILLEGAL_TRAP_EN -> states 0,1,0.
  - With MULTICYCLE_ILLEGAL_TRAP_EN -> state=12, trap=1, held until rst_n=0.
